// File: rtl/control_captura_pkg.sv
// Shared definitions for the keypad operand-capture controller.
package control_captura_pkg;

    // Non-digit key codes; digits map to their own value 0..9.
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // ESPERA waits for the reader to drop pressed_valid, then returns to a saved state.
    typedef enum logic [1:0] {
        CAP_A  = 2'd0,
        CAP_B  = 2'd1,
        ESPERA = 2'd2,
        LISTO  = 2'd3
    } estado_t;

    // Position of the set bit in a 4-bit one-hot vector (0 if none set).
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (v[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/control_captura_decodificador.sv
// Combinational keypad decoder: one-hot row/col to 4-bit key code.
module decodificador_tecla
    import control_captura_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] row,
    input  logic [WIDTH-1:0] col,
    output logic [3:0]       code,
    output logic             valid
);

    logic [1:0] r;
    logic [1:0] c;

    // Map row/column to the key code; a key is valid only with exactly one row and one column.
    always_comb begin
        r     = onehot_idx(row[3:0]);
        c     = onehot_idx(col[3:0]);
        valid = $onehot(row) && $onehot(col);
        code  = 4'd0;
        if (c == 2'd3) begin
            code = KEY_A + {2'b00, r};
        end else if (r == 2'd3) begin
            case (c)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
    end

endmodule

// File: rtl/control_captura.sv
// Keypad entry controller: acknowledges reader keys and assembles two BCD operands.
module control_captura
    import control_captura_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int DIGITS = 3,
    localparam int OW     = 4 * DIGITS,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pressed_valid,
    input  logic [WIDTH-1:0] pressed_col,
    input  logic [WIDTH-1:0] pressed_row,
    output logic             ack_read,
    output logic [OW-1:0]    operand_a,
    output logic [OW-1:0]    operand_b,
    output logic             operands_valid,
    input  logic             operands_ack,
    output logic             entering_b,
    output logic [CW-1:0]    digit_count,
    output logic [3:0]       last_key
);

    estado_t       estado, estado_n, ret, ret_n;
    logic          ack_n, valid_n, entb_n;
    logic [OW-1:0] opa_n, opb_n, cur;
    logic [CW-1:0] cnt_n;
    logic [3:0]    last_n;
    logic [3:0]    key_code;
    logic          key_ok;

    decodificador_tecla #(.WIDTH(WIDTH)) u_dec (
        .row   (pressed_row),
        .col   (pressed_col),
        .code  (key_code),
        .valid (key_ok)
    );

    // State and all outputs are registered; reset returns everything to idle capture of A.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado         <= CAP_A;
            ret            <= CAP_A;
            ack_read       <= 1'b0;
            operand_a      <= '0;
            operand_b      <= '0;
            operands_valid <= 1'b0;
            entering_b     <= 1'b0;
            digit_count    <= '0;
            last_key       <= 4'd0;
        end else begin
            estado         <= estado_n;
            ret            <= ret_n;
            ack_read       <= ack_n;
            operand_a      <= opa_n;
            operand_b      <= opb_n;
            operands_valid <= valid_n;
            entering_b     <= entb_n;
            digit_count    <= cnt_n;
            last_key       <= last_n;
        end
    end

    // Next-state logic: key handling in capture states, release wait, and hand-off in LISTO.
    always_comb begin
        estado_n = estado;
        ret_n    = ret;
        ack_n    = 1'b0;
        opa_n    = operand_a;
        opb_n    = operand_b;
        valid_n  = operands_valid;
        entb_n   = entering_b;
        cnt_n    = digit_count;
        last_n   = last_key;
        cur      = (estado == CAP_B) ? operand_b : operand_a;

        unique case (estado)
            CAP_A, CAP_B: begin
                if (pressed_valid) begin
                    ack_n    = 1'b1;
                    estado_n = ESPERA;
                    ret_n    = estado;
                    if (key_ok) begin
                        last_n = key_code;
                        if (key_code <= 4'd9) begin
                            // A full operand silently drops further digits.
                            if (digit_count < CW'(DIGITS)) begin
                                cur   = {cur[OW-5:0], key_code};
                                cnt_n = digit_count + CW'(1);
                            end
                        end else if (key_code == KEY_STAR) begin
                            cur   = '0;
                            cnt_n = '0;
                        end else if (key_code == KEY_HASH) begin
                            if (estado == CAP_A) begin
                                entb_n = 1'b1;
                                cnt_n  = '0;
                                ret_n  = CAP_B;
                            end else begin
                                valid_n = 1'b1;
                                ret_n   = LISTO;
                            end
                        end
                    end
                    if (estado == CAP_B) opb_n = cur;
                    else                 opa_n = cur;
                end
            end
            ESPERA: begin
                if (!pressed_valid) estado_n = ret;
            end
            LISTO: begin
                // The downstream ack has priority; a simultaneous key stays pending for CAP_A.
                if (operands_ack) begin
                    opa_n    = '0;
                    opb_n    = '0;
                    cnt_n    = '0;
                    entb_n   = 1'b0;
                    valid_n  = 1'b0;
                    estado_n = CAP_A;
                end else if (pressed_valid) begin
                    ack_n    = 1'b1;
                    estado_n = ESPERA;
                    ret_n    = LISTO;
                    if (key_ok && key_code == KEY_STAR) begin
                        // Abort: drop both operands and restart entry once the key is released.
                        opa_n   = '0;
                        opb_n   = '0;
                        cnt_n   = '0;
                        entb_n  = 1'b0;
                        valid_n = 1'b0;
                        last_n  = KEY_STAR;
                        ret_n   = CAP_A;
                    end
                end
            end
            default: estado_n = CAP_A;
        endcase
    end

endmodule

// File: tb/tb_control_captura.sv
// Scoreboard bench for control_captura: model predicts outputs per key, monitor compares on ack/valid edges.
module tb_control_captura;

    localparam int DIGITS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pressed_valid = 1'b0;
    logic [3:0]  pressed_col = 4'd0;
    logic [3:0]  pressed_row = 4'd0;
    logic        operands_ack = 1'b0;
    logic        ack_read;
    logic [11:0] operand_a, operand_b;
    logic        operands_valid;
    logic        entering_b;
    logic [1:0]  digit_count;
    logic [3:0]  last_key;

    control_captura #(.WIDTH(4), .DIGITS(DIGITS)) dut (
        .clk            (clk),
        .rst            (rst),
        .pressed_valid  (pressed_valid),
        .pressed_col    (pressed_col),
        .pressed_row    (pressed_row),
        .ack_read       (ack_read),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .operands_valid (operands_valid),
        .operands_ack   (operands_ack),
        .entering_b     (entering_b),
        .digit_count    (digit_count),
        .last_key       (last_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [1:0]  cnt;
        logic        entb;
        logic [3:0]  last;
        logic        vld;
    } exp_t;

    exp_t ack_q[$];
    exp_t rise_q[$];
    exp_t fall_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_acks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model: operands as lists of entered digits ----------------
    int kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    int qa[$];
    int qb[$];
    int phase = 0;   // 0 entering A, 1 entering B, 2 both ready
    int last  = 0;

    function automatic logic [11:0] pack(input int q[$]);
        int v;
        v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return 12'(v);
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.a    = pack(qa);
        e.b    = pack(qb);
        e.cnt  = 2'((phase == 0) ? qa.size() : qb.size());
        e.entb = (phase != 0);
        e.last = 4'(last);
        e.vld  = (phase == 2);
        return e;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        phase = 0;
    endtask

    task automatic model_key(input logic [3:0] row, input logic [3:0] col);
        int r, c, k;
        if ($countones(row) != 1 || $countones(col) != 1) begin
            ack_q.push_back(snap());
            return;
        end
        r = 0; c = 0;
        for (int i = 0; i < 4; i++) begin
            if (row[i]) r = i;
            if (col[i]) c = i;
        end
        k = kmap[r][c];
        if (phase < 2) begin
            last = k;
            if (k <= 9) begin
                if (phase == 0) begin if (qa.size() < DIGITS) qa.push_back(k); end
                else            begin if (qb.size() < DIGITS) qb.push_back(k); end
            end else if (k == 14) begin
                if (phase == 0) qa.delete(); else qb.delete();
            end else if (k == 15) begin
                if (phase == 0) phase = 1;
                else begin
                    phase = 2;
                    rise_q.push_back(snap());
                end
            end
        end else if (k == 14) begin
            last = 14;
            model_clear();
            fall_q.push_back(snap());
        end
        ack_q.push_back(snap());
    endtask

    // ---------------- monitor ----------------
    logic prev_ack = 1'b0;
    logic prev_vld = 1'b0;

    // Compare DUT state against the oldest prediction whenever an ack or valid edge appears.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ack_read) begin
                n_acks++;
                chk("ack_single_cycle", 32'(prev_ack), 32'(0));
                if (ack_q.size() == 0) chk("ack_unexpected", 32'(1), 32'(0));
                else begin
                    e = ack_q.pop_front();
                    chk("ack_operand_a", 32'(operand_a), 32'(e.a));
                    chk("ack_operand_b", 32'(operand_b), 32'(e.b));
                    chk("ack_digit_count", 32'(digit_count), 32'(e.cnt));
                    chk("ack_entering_b", 32'(entering_b), 32'(e.entb));
                    chk("ack_last_key", 32'(last_key), 32'(e.last));
                    chk("ack_operands_valid", 32'(operands_valid), 32'(e.vld));
                end
            end
            if (operands_valid && !prev_vld) begin
                if (rise_q.size() == 0) chk("valid_rise_unexpected", 32'(1), 32'(0));
                else begin
                    e = rise_q.pop_front();
                    chk("rise_operand_a", 32'(operand_a), 32'(e.a));
                    chk("rise_operand_b", 32'(operand_b), 32'(e.b));
                end
            end
            if (!operands_valid && prev_vld) begin
                if (fall_q.size() == 0) chk("valid_fall_unexpected", 32'(1), 32'(0));
                else begin
                    e = fall_q.pop_front();
                    chk("fall_operand_a", 32'(operand_a), 32'(e.a));
                    chk("fall_operand_b", 32'(operand_b), 32'(e.b));
                    chk("fall_digit_count", 32'(digit_count), 32'(e.cnt));
                    chk("fall_entering_b", 32'(entering_b), 32'(e.entb));
                end
            end
            prev_ack = ack_read;
            prev_vld = operands_valid;
        end else begin
            prev_ack = 1'b0;
            prev_vld = 1'b0;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ack();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_read) begin ok = 1; break; end
        end
        if (!ok) chk("ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic press(input logic [3:0] r, input logic [3:0] c, input int hold, input bit with_oack);
        if (with_oack) begin
            model_clear();
            fall_q.push_back(snap());
        end
        model_key(r, c);
        pressed_row   = r;
        pressed_col   = c;
        pressed_valid = 1'b1;
        if (with_oack) begin
            operands_ack = 1'b1;
            @(negedge clk);
            operands_ack = 1'b0;
        end
        wait_ack();
        repeat (hold) @(negedge clk);
        pressed_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic k_rc(input int k, output logic [3:0] r, output logic [3:0] c);
        r = 4'd0; c = 4'd0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (kmap[i][j] == k) begin r = 4'(1 << i); c = 4'(1 << j); end
    endtask

    task automatic key(input int k, input int hold = 0, input bit with_oack = 0);
        logic [3:0] r, c;
        k_rc(k, r, c);
        press(r, c, hold, with_oack);
    endtask

    task automatic do_ack();
        model_clear();
        fall_q.push_back(snap());
        operands_ack = 1'b1;
        @(negedge clk);
        operands_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack_read"}, 32'(ack_read), 32'(0));
        chk({tag, "_operands_valid"}, 32'(operands_valid), 32'(0));
        chk({tag, "_entering_b"}, 32'(entering_b), 32'(0));
        chk({tag, "_operand_a"}, 32'(operand_a), 32'(0));
        chk({tag, "_operand_b"}, 32'(operand_b), 32'(0));
        chk({tag, "_digit_count"}, 32'(digit_count), 32'(0));
        chk({tag, "_last_key"}, 32'(last_key), 32'(0));
    endtask

    initial begin
        logic [3:0] r, c;
        int acks0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Operand entry: 1,2,#,3,#
        key(1); key(2); key(15); key(3); key(15);
        chk("entry_operand_a", 32'(operand_a), 32'h012);
        chk("entry_operand_b", 32'(operand_b), 32'h003);
        chk("entry_valid", 32'(operands_valid), 32'(1));
        do_ack();
        chk("entry_cleared_a", 32'(operand_a), 32'h000);

        // Digit overflow
        key(9); key(8); key(7); key(6);
        chk("overflow_operand_a", 32'(operand_a), 32'h987);
        chk("overflow_digit_count", 32'(digit_count), 32'(3));
        key(15); key(15); do_ack();

        // Clear within an operand
        key(5); key(14); key(4); key(15);
        chk("clear_operand_a", 32'(operand_a), 32'h004);
        key(15); do_ack();

        // Long press: exactly one ack, one digit
        acks0 = n_acks;
        key(3, 10);
        chk("long_press_acks", 32'(n_acks - acks0), 32'(1));
        chk("long_press_count", 32'(digit_count), 32'(1));
        key(14);

        // Invalid row, then letter A
        press(4'b0011, 4'b0001, 0, 0);
        key(10);
        chk("letter_last_key", 32'(last_key), 32'(10));
        chk("letter_operand_a", 32'(operand_a), 32'h000);

        // Simultaneous ack and key in LISTO
        key(15); key(2); key(15);
        key(7, 0, 1);
        chk("simul_operand_a", 32'(operand_a), 32'h007);

        // Reset in the middle of a handshake; the held key is taken again afterwards
        k_rc(4, r, c);
        model_key(r, c);
        pressed_row = r; pressed_col = c; pressed_valid = 1'b1;
        wait_ack();
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset("midreset");
        model_clear();
        last = 0;
        model_key(r, c);
        rst = 1'b0;
        wait_ack();
        pressed_valid = 1'b0;
        @(negedge clk);
        chk("midreset_rekey_a", 32'(operand_a), 32'h004);

        // Randomized key stream
        for (int it = 0; it < 150; it++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (phase == 2 && sel < 3) do_ack();
            else if (sel == 3) press(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 0);
            else if (sel < 6) key(15, int'($urandom_range(0, 2)), 0);
            else begin
                r = 4'(1 << $urandom_range(0, 3));
                c = 4'(1 << $urandom_range(0, 3));
                press(r, c, int'($urandom_range(0, 3)), (phase == 2) && ($urandom_range(0, 3) == 0));
            end
        end

        repeat (4) @(negedge clk);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'(0));
        chk("rise_queue_drained", 32'(rise_q.size()), 32'(0));
        chk("fall_queue_drained", 32'(fall_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
